// File: rtl/cube_scan_sequencer.sv
// Sticker scan sequencer: walks every non-center sticker in order and requests a setup move
// for each one. It then waits for the colour sensor to settle, accepts a colour after SAMPLES
// identical valid readings and packs it into the cube-state vector. After the last sticker it
// checks the per-colour counts before handing the state to the solver.
//
// Ports:
//   clock           system clock
//   reset_n         synchronous active-low reset
//   start           one-cycle pulse, begins a scan when not busy
//   move_req        setup move request for step_index, held until move_done
//   step_index      sticker currently being scanned
//   move_done       one-cycle pulse from the move sequencer
//   sensor_stable   colour sensors have settled
//   corner_color    corner sensor reading
//   edge_color      edge sensor reading
//   busy            scan in progress
//   cubestate       packed sticker colours, slot i at [COLOR_W*i +: COLOR_W]
//   cubestate_valid cubestate holds a checked scan
//   error           scan aborted, see error_code
//   error_code      1 = sample retries exhausted, 2 = stable timeout, 3 = colour count mismatch
module cube_scan_sequencer #(
  parameter int unsigned COLOR_W        = 3,
  parameter int unsigned N_CORNER       = 24,
  parameter int unsigned N_EDGE         = 24,
  parameter int unsigned N_CENTER       = 6,
  parameter int unsigned SAMPLES        = 3,
  parameter int unsigned MAX_RETRY      = 2,
  parameter int unsigned STABLE_TIMEOUT = 1000000,
  localparam int unsigned N_SCAN        = N_CORNER + N_EDGE,
  localparam int unsigned N_ALL         = N_SCAN + N_CENTER,
  localparam int unsigned IDX_W         = ($clog2(N_SCAN) > 6) ? $clog2(N_SCAN) : 6
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  output logic                       move_req,
  output logic [IDX_W-1:0]           step_index,
  input  logic                       move_done,
  input  logic                       sensor_stable,
  input  logic [COLOR_W-1:0]         corner_color,
  input  logic [COLOR_W-1:0]         edge_color,
  output logic                       busy,
  output logic [N_ALL*COLOR_W-1:0]   cubestate,
  output logic                       cubestate_valid,
  output logic                       error,
  output logic [1:0]                 error_code
);

  localparam int unsigned ST_W  = N_ALL * COLOR_W;
  localparam int unsigned CNT_W = $clog2(N_ALL + 1);
  localparam int unsigned TO_W  = $clog2(STABLE_TIMEOUT + 1);
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned SMP_W = 4;

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(N_SCAN - 1);
  localparam logic [IDX_W-1:0]   FIRST_EDGE = IDX_W'(N_CORNER);
  localparam logic [COLOR_W-1:0] MAX_CODE   = COLOR_W'(5);
  localparam logic [CNT_W-1:0]   CNT_TARGET = CNT_W'(N_ALL / 6);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(STABLE_TIMEOUT - 1);
  localparam logic [RTY_W-1:0]   RTY_MAX    = RTY_W'(MAX_RETRY);
  localparam logic [SMP_W-1:0]   SMP_LAST   = SMP_W'(SAMPLES - 1);

  // Centers hold codes 0..5 in slot order; every scanned slot starts at 0.
  function automatic logic [ST_W-1:0] init_cube();
    logic [ST_W-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < N_CENTER; k++) begin
      v[COLOR_W*(N_SCAN+k) +: COLOR_W] = COLOR_W'(k % 6);
    end
    return v;
  endfunction

  localparam logic [ST_W-1:0] CUBE_INIT = init_cube();

  typedef enum logic [2:0] {
    StIdle, StReq, StWaitStable, StSample, StCommit, StCheck, StDone, StError
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   step_q, step_d;
  logic [ST_W-1:0]    cube_q, cube_d;
  logic [CNT_W-1:0]   count_q [6];
  logic [CNT_W-1:0]   count_d [6];
  logic [TO_W-1:0]    to_q, to_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [SMP_W-1:0]   smp_q, smp_d;
  logic [COLOR_W-1:0] ref_q, ref_d;
  logic [1:0]         code_q, code_d;

  logic [COLOR_W-1:0] reading;
  logic               sample_bad;
  logic               counts_ok;

  assign reading = (step_q < FIRST_EDGE) ? corner_color : edge_color;

  // The first sample of a window only has to be a valid code; later ones must match it.
  assign sample_bad = !sensor_stable || (reading > MAX_CODE) ||
                      ((smp_q != '0) && (reading != ref_q));

  always_comb begin
    counts_ok = 1'b1;
    for (int unsigned c = 0; c < 6; c++) begin
      if (count_q[c] != CNT_TARGET) counts_ok = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cube_d  = cube_q;
    count_d = count_q;
    to_d    = to_q;
    retry_d = retry_q;
    smp_d   = smp_q;
    ref_d   = ref_q;
    code_d  = code_q;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d = StReq;
          step_d  = '0;
          cube_d  = CUBE_INIT;
          for (int unsigned c = 0; c < 6; c++) count_d[c] = CNT_W'(1);
          to_d    = '0;
          retry_d = '0;
          smp_d   = '0;
          code_d  = 2'd0;
        end
      end
      StReq: begin
        if (move_done) state_d = StWaitStable;
      end
      StWaitStable: begin
        if (sensor_stable) begin
          state_d = StSample;
          to_d    = '0;
          smp_d   = '0;
        end else if (to_q == TO_LAST) begin
          state_d = StError;
          code_d  = 2'd2;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      StSample: begin
        if (sample_bad) begin
          if (retry_q == RTY_MAX) begin
            state_d = StError;
            code_d  = 2'd1;
          end else begin
            retry_d = retry_q + RTY_W'(1);
            state_d = StWaitStable;
          end
        end else begin
          if (smp_q == '0) ref_d = reading;
          if (smp_q == SMP_LAST) begin
            state_d = StCommit;
          end else begin
            smp_d = smp_q + SMP_W'(1);
          end
        end
      end
      StCommit: begin
        cube_d[COLOR_W*int'(step_q) +: COLOR_W] = ref_q;
        for (int unsigned c = 0; c < 6; c++) begin
          if (ref_q == COLOR_W'(c)) count_d[c] = count_q[c] + CNT_W'(1);
        end
        retry_d = '0;
        if (step_q == LAST_IDX) begin
          state_d = StCheck;
        end else begin
          step_d  = step_q + IDX_W'(1);
          state_d = StReq;
        end
      end
      StCheck: begin
        if (counts_ok) begin
          state_d = StDone;
        end else begin
          state_d = StError;
          code_d  = 2'd3;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StIdle;
      step_q  <= '0;
      cube_q  <= CUBE_INIT;
      for (int unsigned c = 0; c < 6; c++) count_q[c] <= CNT_W'(1);
      to_q    <= '0;
      retry_q <= '0;
      smp_q   <= '0;
      ref_q   <= '0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cube_q  <= cube_d;
      count_q <= count_d;
      to_q    <= to_d;
      retry_q <= retry_d;
      smp_q   <= smp_d;
      ref_q   <= ref_d;
      code_q  <= code_d;
    end
  end

  assign move_req        = (state_q == StReq);
  assign step_index      = step_q;
  assign busy            = !((state_q == StIdle) || (state_q == StDone) || (state_q == StError));
  assign cubestate       = cube_q;
  assign cubestate_valid = (state_q == StDone);
  assign error           = (state_q == StError);
  assign error_code      = code_q;

endmodule

// File: doc/cube_scan_sequencer.md
Name: cube_scan_sequencer

Overview:
Parametrised successor to the single-pass sticker scanner. It steps through every non-center sticker and requests the setup move for each one from the move sequencer. For each sticker it waits for the colour sensor to settle, takes N agreeing samples from the corner or edge sensor, and packs the result into the cube-state vector. It validates colour counts before handing the state to the solver, and reports errors and timeouts instead of hanging.

Parameters:
COLOR_W, 3, bits per sticker colour code (valid codes 0..5: W,O,G,R,B,Y).
N_CORNER, 24, corner stickers scanned first, slots 0..N_CORNER-1.
N_EDGE, 24, edge stickers, slots N_CORNER..N_CORNER+N_EDGE-1.
N_CENTER, 6, fixed center slots above the edges, loaded with codes 0..5 in order (W at lowest center slot).
SAMPLES, 3, consecutive identical readings required to accept a sticker (1..15).
MAX_RETRY, 2, sample-window restarts allowed per sticker before error.
STABLE_TIMEOUT, 1000000, maximum cycles waiting for sensor_stable.

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse, begins scan when idle
move_req  out  1  request setup move for step_index; held until move_done
step_index  out  6  sticker index 0..N_CORNER+N_EDGE-1 (width ceil-log2 of total, min 6)
move_done  in  1  one-cycle pulse from move sequencer, move finished
sensor_stable  in  1  level, colour sensors settled
corner_color  in  COLOR_W  corner sensor reading
edge_color  in  COLOR_W  edge sensor reading
busy  out  1  high from start acceptance until DONE/ERROR
cubestate  out  (N_CORNER+N_EDGE+N_CENTER)*COLOR_W  packed state, valid when cubestate_valid
cubestate_valid  out  1  level, high in DONE
error  out  1  level, high in ERROR
error_code  out  2  1=sample retries exhausted, 2=stable timeout, 3=colour count mismatch

Behaviour:
- Reset (reset_n low at clock edge): state IDLE. move_req=0, busy=0, cubestate_valid=0, error=0, error_code=0, step_index=0. cubestate = centers loaded, all other slots 0. All colour counters = 1 (one per center). Reset wins over every other input, including mid-scan.
- IDLE: start=1 -> REQ next cycle; busy=1. Starting also clears the non-center slots and counters, so a re-scan from DONE/ERROR is identical to a scan from reset.
- REQ: move_req=1 and step_index stable until the cycle move_done=1, then -> WAIT_STABLE with move_req=0 the next cycle. move_done while not in REQ is ignored.
- WAIT_STABLE: timeout counter increments each cycle. sensor_stable=1 -> SAMPLE and the counter is cleared. Counter reaches STABLE_TIMEOUT -> ERROR, code 2.
- SAMPLE: sensor selection uses corner_color when step_index<N_CORNER, otherwise edge_color.
  - First sample is captured as the reference.
  - Each subsequent cycle compares the reading to the reference.
  - On SAMPLES consecutive equal, valid (<=5) readings -> COMMIT. Minimum SAMPLE dwell is SAMPLES cycles.
  - Mismatch, invalid code, or sensor_stable dropping -> retry count +1 and back to WAIT_STABLE.
  - If the retry count exceeds MAX_RETRY -> ERROR, code 1. The retry count resets per sticker.
- COMMIT (1 cycle): write the reference into slot step_index (bits [COLOR_W*step_index +: COLOR_W]) and increment that colour's counter.
  - If this was the last sticker -> CHECK.
  - Otherwise step_index+1 and -> REQ.
- CHECK (1 cycle): every counter == (N_CORNER+N_EDGE+N_CENTER)/6 -> DONE, else -> ERROR code 3.
- DONE: cubestate_valid=1, busy=0; cubestate held. start -> new scan; cubestate_valid drops the cycle after start.
- ERROR: error=1, busy=0; error_code and step_index held for debug. start clears error and begins a new scan.
- start while busy is ignored.
- Counters are wide enough for the total sticker count; no wrap is possible in legal operation.

Test Plan:
- Solved-cube stimulus: each sensor returns the correct colour and move_done arrives 5 cycles after move_req. Required: 48 move_req handshakes with step_index 0..47; cubestate_valid=1, counts 9 each; cubestate matches the expected packed vector; error=0.
- Sticker 3 corner readings 2,2,4 then 2,2,2 (SAMPLES=3). Required: one retry; slot 3 = 2; scan completes; no error.
- Sticker 30 edge reading constant 7 (invalid). Required: after 3 sample windows, ERROR with error_code=1 and step_index=30; move_req stays 0.
- sensor_stable held low, STABLE_TIMEOUT=50. Required: ERROR code 2 exactly 50 cycles after entering WAIT_STABLE for sticker 0.
- All stickers read 0 (W). Required: CHECK fails -> error_code=3, cubestate_valid=0.
- reset_n low during REQ of sticker 20 while start pulses repeatedly. Required: all outputs return to reset values the next cycle; start pulses during busy are ignored; a following start rescans from step_index 0 with centers intact.
